// File: rtl/data_sram_pkg.sv
// Shared types and helpers for the data-side SRAM request block.
package data_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned LAT_CNT_W = 4;

    // Byte-offset width of one data word.
    function automatic int unsigned off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed storage with per-byte write enables and a combinational read port.
module sram_byte_array #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        wstrb,
    input  logic [$clog2(DEPTH)-1:0]   windex,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   rindex,
    output logic [DATA_W-1:0]          rdata
);

    localparam int unsigned STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_q[windex][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[rindex];

endmodule

// File: rtl/data_sram_req.sv
// Data SRAM behind a single-outstanding valid/ready request/response handshake
// with programmable read latency and out-of-range detection.
module data_sram_req
    import data_sram_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned OFF_W = off_w(DATA_W);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("data_sram_req: DATA_W must be 32 or 64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_sram_req: DEPTH must be a power of two >= 2");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("data_sram_req: LATENCY must be in 1..8");
    end

    state_e                 state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   wr_q, wr_d;
    logic                   err_q, err_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   rerr_q, rerr_d;

    logic [ADDR_W-1:0]      word_addr;
    logic [IDX_W-1:0]       req_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   out_of_range;
    logic                   accept;
    logic                   array_we;
    logic [DATA_W-1:0]      array_rdata;

    // Range check uses the whole word address so high bits never alias into the array.
    assign word_addr    = req_addr >> OFF_W;
    assign out_of_range = word_addr >= ADDR_W'(DEPTH);
    assign req_idx      = word_addr[IDX_W-1:0];

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign array_we  = accept && req_wr && !out_of_range;
    assign rd_idx    = (state_q == ST_IDLE) ? req_idx : idx_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

    sram_byte_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .we     (array_we),
        .wstrb  (req_wstrb),
        .windex (req_idx),
        .wdata  (req_wdata),
        .rindex (rd_idx),
        .rdata  (array_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    // Next-state and response capture; read data is sampled on the edge entering RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rerr_d  = rerr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    idx_d = req_idx;
                    wr_d  = req_wr;
                    err_d = out_of_range;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        rerr_d  = out_of_range;
                        rdata_d = (req_wr || out_of_range) ? '0 : array_rdata;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (cnt_q == LAT_CNT_W'(1)) begin
                    state_d = ST_RESP;
                    rerr_d  = err_q;
                    rdata_d = (wr_q || err_q) ? '0 : array_rdata;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_sram_req.sv
// Randomised and directed checks of data_sram_req at latencies 2, 1 and 8
// against a word-array reference model.
module tb_data_sram_req;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;

    logic [2:0]        req_valid;
    logic [2:0]        rsp_ready;
    logic [2:0]        req_ready;
    logic [2:0]        rsp_valid;
    logic [2:0]        rsp_err;
    logic [2:0][63:0]  rsp_rdata;

    logic [63:0] mem_m [3][128];
    int          lat_of [3] = '{2, 1, 8};
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    data_sram_req #(.DATA_W(64), .ADDR_W(64), .DEPTH(128), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_sram_req #(.DATA_W(64), .ADDR_W(64), .DEPTH(128), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_sram_req #(.DATA_W(64), .ADDR_W(64), .DEPTH(128), .LATENCY(8)) u_lat8 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_wr(req_wr),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete request/response on DUT d, optionally stalling the response for bp cycles.
    task automatic txn(input int d, input bit wr, input logic [63:0] addr,
                       input logic [7:0] strb, input logic [63:0] wd, input int bp);
        logic [63:0] exp_d;
        bit          exp_e;
        int          idx;
        int          n;
        exp_e = (addr / 64'd8) >= 64'd128;
        idx   = exp_e ? 0 : int'(addr / 64'd8);
        exp_d = (wr || exp_e) ? 64'd0 : mem_m[d][idx];
        if (wr && !exp_e) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end

        @(posedge clk); #1;
        req_wr       = wr;
        req_addr     = addr;
        req_wstrb    = strb;
        req_wdata    = wd;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (bp == 0);
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 64'(req_ready[d]), 64'd1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid[d] && n < 20);
        check("latency", 64'(n), 64'(lat_of[d]));
        check("rdata", rsp_rdata[d], exp_d);
        check("err", 64'(rsp_err[d]), 64'(exp_e));

        if (bp > 0) begin
            req_valid[d] = 1'b1;
            for (int c = 0; c < bp; c++) begin
                @(negedge clk);
                check("bp_valid", 64'(rsp_valid[d]), 64'd1);
                check("bp_rdata", rsp_rdata[d], exp_d);
                check("bp_err", 64'(rsp_err[d]), 64'(exp_e));
                check("bp_ready", 64'(req_ready[d]), 64'd0);
            end
            @(posedge clk); #1;
            req_valid[d] = 1'b0;
            rsp_ready[d] = 1'b1;
        end

        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        check("idle_ready", 64'(req_ready[d]), 64'd1);
        check("idle_valid", 64'(rsp_valid[d]), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        int          r;

        reset     = 1'b1;
        req_valid = 3'b111;
        rsp_ready = 3'b000;
        req_wr    = 1'b1;
        req_addr  = 64'h0;
        req_wstrb = 8'hFF;
        req_wdata = 64'hDEAD_BEEF_0000_1111;

        // Reset held with requests pending.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check("rst_ready", 64'(req_ready[d]), 64'd0);
                check("rst_valid", 64'(rsp_valid[d]), 64'd0);
                check("rst_rdata", rsp_rdata[d], 64'd0);
                check("rst_err", 64'(rsp_err[d]), 64'd0);
            end
        end
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) check("post_rst_ready", 64'(req_ready[d]), 64'd1);

        // Fill DUT 0 so every later read has defined contents.
        for (int i = 0; i < 128; i++) begin
            txn(0, 1'b1, 64'(i * 8), 8'hFF, {$urandom, $urandom}, 0);
        end

        // Full write then offset read at every latency.
        for (int d = 0; d < 3; d++) begin
            txn(d, 1'b1, 64'h40, 8'hFF, 64'h0123_4567_89AB_CDEF, 0);
            txn(d, 1'b0, 64'h47, 8'h00, 64'h0, 0);
        end

        // Partial strobe and a no-op write.
        txn(0, 1'b1, 64'h40, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        txn(0, 1'b0, 64'h40, 8'h00, 64'h0, 0);
        txn(0, 1'b1, 64'h40, 8'h00, 64'h1111_2222_3333_4444, 0);
        txn(0, 1'b0, 64'h40, 8'h00, 64'h0, 0);

        // Out of range: first word past the array must not alias onto word 0.
        txn(0, 1'b1, 64'h400, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA, 0);
        txn(0, 1'b0, 64'h400, 8'h00, 64'h0, 0);
        txn(0, 1'b0, 64'h0, 8'h00, 64'h0, 0);
        txn(0, 1'b0, 64'h8000_0000_0000_0000, 8'h00, 64'h0, 0);

        // Response backpressure with a competing request.
        txn(0, 1'b0, 64'h40, 8'h00, 64'h0, 5);
        txn(2, 1'b0, 64'h40, 8'h00, 64'h0, 3);

        // Reset while a read is waiting drops the response; the earlier write survives.
        txn(0, 1'b1, 64'h8, 8'hFF, 64'h55, 0);
        @(posedge clk); #1;
        req_wr       = 1'b0;
        req_addr     = 64'h8;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset        = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midrst_valid", 64'(rsp_valid[0]), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("postrst_valid", 64'(rsp_valid[0]), 64'd0);
        end
        txn(0, 1'b0, 64'h8, 8'h00, 64'h0, 0);

        // Random traffic on the latency-2 instance.
        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = {$urandom, $urandom};
            else if (r == 1) a = 64'(1024 + $urandom_range(0, 1023));
            else             a = 64'($urandom_range(0, 1023));
            txn(0, 1'($urandom_range(0, 1)), a, 8'($urandom), {$urandom, $urandom},
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
